// File: rtl/alu_pkg.sv
// Shared ALU op codes (also used by the ALU control decoder) and execute-stage FSM states.
package alu_pkg;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_XOR  = 3'b001;
    localparam logic [2:0] OP_SLL  = 3'b010;
    localparam logic [2:0] OP_ADD  = 3'b011;
    localparam logic [2:0] OP_SUB  = 3'b100;
    localparam logic [2:0] OP_MUL  = 3'b101;
    localparam logic [2:0] OP_ADDI = 3'b110;
    localparam logic [2:0] OP_SRAI = 3'b111;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_MUL  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/alu_iter_mul.sv
// Iterative shift-add multiplier: one partial-product step per cycle, WIDTH steps per start.
// Used by alu_exec_unit only when ITER_MUL_EN is defined.
module alu_iter_mul
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] mcand,
    input  logic [WIDTH-1:0] mplier,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH);

    logic             busy;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] mcand_sr;
    logic [WIDTH-1:0] mplier_sr;
    logic [WIDTH-1:0] acc;

    // High during the cycle whose rising edge performs the final step.
    assign done    = busy && (cnt == CW'(WIDTH - 1));
    assign product = acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy      <= 1'b0;
            cnt       <= '0;
            mcand_sr  <= '0;
            mplier_sr <= '0;
            acc       <= '0;
        end else if (start) begin
            busy      <= 1'b1;
            cnt       <= '0;
            mcand_sr  <= mcand;
            mplier_sr <= mplier;
            acc       <= '0;
        end else if (busy) begin
            if (mplier_sr[0]) begin
                acc <= acc + mcand_sr;
            end
            mcand_sr  <= mcand_sr << 1;
            mplier_sr <= mplier_sr >> 1;
            cnt       <= cnt + CW'(1);
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Handshaked ALU execute stage with a registered result.
// ITER_MUL_EN defined: MUL runs iteratively (WIDTH+1 cycles); undefined: single-cycle multiply.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [2:0]       ctrl_i,
    input  logic [WIDTH-1:0] data1_i,
    input  logic [WIDTH-1:0] data2_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] data_o,
    output logic             zero_o,
    output logic [1:0]       dbg_state_o
);

    localparam int SW = $clog2(WIDTH);

    // Handshake: a transfer happens on a rising edge where valid and ready are both high;
    // valid stays up and its payload stays stable until that transfer occurs.
    state_t           state;
    logic             accept;
    logic [SW-1:0]    shamt;
    logic [WIDTH-1:0] result;

    assign ready_o     = (state == ST_IDLE) && (!valid_o || ready_i);
    assign accept      = valid_i && ready_o;
    assign shamt       = data2_i[SW-1:0];
    assign dbg_state_o = state;

    always_comb begin
        result = '0;
        case (ctrl_i)
            OP_AND:  result = data1_i & data2_i;
            OP_XOR:  result = data1_i ^ data2_i;
            OP_SLL:  result = data1_i << shamt;
            OP_ADD:  result = data1_i + data2_i;
            OP_SUB:  result = data1_i - data2_i;
`ifdef ITER_MUL_EN
            OP_MUL:  result = '0;
`else
            OP_MUL:  result = data1_i * data2_i;
`endif
            OP_ADDI: result = data1_i + data2_i;
            OP_SRAI: result = WIDTH'($signed(data1_i) >>> shamt);
            default: result = '0;
        endcase
    end

`ifdef ITER_MUL_EN
    logic             mul_done;
    logic [WIDTH-1:0] mul_product;

    alu_iter_mul #(.WIDTH(WIDTH)) u_iter_mul (
        .clk     (clk_i),
        .rst     (rst_i),
        .start   (accept && (ctrl_i == OP_MUL)),
        .mcand   (data1_i),
        .mplier  (data2_i),
        .done    (mul_done),
        .product (mul_product)
    );
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= ST_IDLE;
            valid_o <= 1'b0;
            data_o  <= '0;
            zero_o  <= 1'b1;
        end else begin
            if (valid_o && ready_i) begin
                valid_o <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    if (accept) begin
`ifdef ITER_MUL_EN
                        if (ctrl_i == OP_MUL) begin
                            state <= ST_MUL;
                        end else begin
                            data_o  <= result;
                            zero_o  <= (result == '0);
                            valid_o <= 1'b1;
                        end
`else
                        data_o  <= result;
                        zero_o  <= (result == '0);
                        valid_o <= 1'b1;
`endif
                    end
                end
`ifdef ITER_MUL_EN
                ST_MUL: begin
                    if (mul_done) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    data_o  <= mul_product;
                    zero_o  <= (mul_product == '0);
                    valid_o <= 1'b1;
                    state   <= ST_IDLE;
                end
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit; latency expectations follow ITER_MUL_EN.
module tb_alu_exec_unit;

    localparam int WIDTH = 32;
    localparam logic [2:0] OPC_AND  = 3'b000;
    localparam logic [2:0] OPC_SLL  = 3'b010;
    localparam logic [2:0] OPC_ADD  = 3'b011;
    localparam logic [2:0] OPC_SUB  = 3'b100;
    localparam logic [2:0] OPC_MUL  = 3'b101;
    localparam logic [2:0] OPC_ADDI = 3'b110;
    localparam logic [2:0] OPC_SRAI = 3'b111;
`ifdef ITER_MUL_EN
    localparam int MUL_LAT = WIDTH + 1;
`else
    localparam int MUL_LAT = 1;
`endif

    logic             clk = 1'b0;
    logic             rst_i;
    logic             valid_i;
    logic             ready_o;
    logic [2:0]       ctrl_i;
    logic [WIDTH-1:0] data1_i;
    logic [WIDTH-1:0] data2_i;
    logic             valid_o;
    logic             ready_i;
    logic [WIDTH-1:0] data_o;
    logic             zero_o;
    logic [1:0]       dbg_state_o;

    int n_checks = 0;
    int n_pass   = 0;
    logic [WIDTH-1:0] exp_q[$];

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    alu_exec_unit #(.WIDTH(WIDTH)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .ctrl_i      (ctrl_i),
        .data1_i     (data1_i),
        .data2_i     (data2_i),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .data_o      (data_o),
        .zero_o      (zero_o),
        .dbg_state_o (dbg_state_o)
    );

    // reference model: the arithmetic rules stated directly
    function automatic logic [WIDTH-1:0] model(input logic [2:0] op, input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
        int unsigned sh;
        logic [63:0] p;
        logic signed [WIDTH-1:0] sa;
        sh = b % WIDTH;
        p  = {32'b0, a} * {32'b0, b};
        sa = a;
        case (op)
            3'd0: return a & b;
            3'd1: return a ^ b;
            3'd2: return a << sh;
            3'd3: return a + b;
            3'd4: return a - b;
            3'd5: return p[WIDTH-1:0];
            3'd6: return a + b;
            default: return WIDTH'(sa >>> sh);
        endcase
    endfunction

    function automatic logic [WIDTH-1:0] pick_operand();
        case ($urandom_range(0, 3))
            0: return '0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    task automatic apply_reset();
        rst_i   = 1'b1;
        valid_i = 1'b0;
        ready_i = 1'b1;
        ctrl_i  = '0;
        data1_i = '0;
        data2_i = '0;
        repeat (2) @(posedge clk);
        #1 rst_i = 1'b0;
    endtask

    // driver: present one request, wait for accept, then count cycles until valid_o
    task automatic run_op(input logic [2:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          output int lat, output logic busy_ok);
        int n;
        @(negedge clk);
        ctrl_i  = op;
        data1_i = a;
        data2_i = b;
        valid_i = 1'b1;
        n = 0;
        while (!ready_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (ready_o !== 1'b1) $display("FAIL accept_wait: ready_o=%b after %0d cycles, required 1", ready_o, n);
        else n_pass++;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        ctrl_i  = 3'($urandom);
        data1_i = $urandom;
        data2_i = $urandom;
        lat = 0;
        busy_ok = 1'b1;
        while (lat < 200) begin
            @(negedge clk);
            lat++;
            if (valid_o) break;
            if (ready_o) busy_ok = 1'b0;
        end
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        n_checks++;
        if (valid_o !== 1'b0) $display("FAIL reset_valid: got %b, required 0", valid_o); else n_pass++;
        n_checks++;
        if (data_o !== '0) $display("FAIL reset_data: got %h, required 0", data_o); else n_pass++;
        n_checks++;
        if (zero_o !== 1'b1) $display("FAIL reset_zero: got %b, required 1", zero_o); else n_pass++;
        n_checks++;
        if (ready_o !== 1'b1) $display("FAIL reset_ready: got %b, required 1", ready_o); else n_pass++;
        n_checks++;
        if (dbg_state_o !== 2'd0) $display("FAIL reset_state: got %0d, required 0", dbg_state_o); else n_pass++;
    endtask

    task automatic test_directed();
        logic [2:0]       ops  [6] = '{OPC_ADD, OPC_SUB, OPC_ADDI, OPC_SRAI, OPC_SLL, OPC_MUL};
        logic [WIDTH-1:0] as   [6] = '{32'd5, 32'd9, 32'h7FFF_FFFF, 32'h8000_0000, 32'd1, 32'hFFFF_FFFF};
        logic [WIDTH-1:0] bs   [6] = '{32'd7, 32'd9, 32'd1, 32'd4, 32'd33, 32'd3};
        logic [WIDTH-1:0] exps [6] = '{32'd12, 32'd0, 32'h8000_0000, 32'hF800_0000, 32'd2, 32'hFFFF_FFFD};
        int   lat;
        logic busy_ok;
        for (int i = 0; i < 6; i++) begin
            run_op(ops[i], as[i], bs[i], lat, busy_ok);
            n_checks++;
            if (data_o !== exps[i]) $display("FAIL dir_data[%0d]: got %h, required %h", i, data_o, exps[i]);
            else n_pass++;
            n_checks++;
            if (zero_o !== (exps[i] == '0)) $display("FAIL dir_zero[%0d]: got %b, required %b", i, zero_o, exps[i] == '0);
            else n_pass++;
            n_checks++;
            if (lat !== ((ops[i] == OPC_MUL) ? MUL_LAT : 1))
                $display("FAIL dir_latency[%0d]: got %0d, required %0d", i, lat, (ops[i] == OPC_MUL) ? MUL_LAT : 1);
            else n_pass++;
            if (ops[i] == OPC_MUL) begin
                n_checks++;
                if (!busy_ok) $display("FAIL dir_mul_ready: ready_o rose before result, required 0");
                else n_pass++;
            end
        end
    endtask

    task automatic test_random();
        logic [2:0]       op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] exp;
        int   lat;
        logic busy_ok;
        for (int i = 0; i < 24; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = pick_operand();
            b  = pick_operand();
            exp = model(op, a, b);
            run_op(op, a, b, lat, busy_ok);
            n_checks++;
            if (data_o !== exp || zero_o !== (exp == '0))
                $display("FAIL rand_result[%0d] op=%0d a=%h b=%h: got %h/%b, required %h/%b",
                         i, op, a, b, data_o, zero_o, exp, exp == '0);
            else n_pass++;
            n_checks++;
            if (lat !== ((op == OPC_MUL) ? MUL_LAT : 1))
                $display("FAIL rand_latency[%0d] op=%0d: got %0d, required %0d", i, op, lat, (op == OPC_MUL) ? MUL_LAT : 1);
            else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        logic [WIDTH-1:0] a0;
        logic [WIDTH-1:0] a1;
        logic [WIDTH-1:0] exp_a;
        logic [WIDTH-1:0] exp_b;
        int   lat;
        logic busy_ok;
        @(negedge clk);
        ready_i = 1'b0;
        a0 = $urandom;
        a1 = $urandom;
        exp_a = model(OPC_ADD, a0, a1);
        exp_b = model(OPC_SUB, a1, a0);
        run_op(OPC_ADD, a0, a1, lat, busy_ok);
        ctrl_i  = OPC_SUB;
        data1_i = a1;
        data2_i = a0;
        valid_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            n_checks++;
            if (ready_o !== 1'b0 || valid_o !== 1'b1 || data_o !== exp_a)
                $display("FAIL bp_hold[%0d]: ready_o=%b valid_o=%b data_o=%h, required 0/1/%h",
                         k, ready_o, valid_o, data_o, exp_a);
            else n_pass++;
            @(negedge clk);
        end
        ready_i = 1'b1;
        #1;
        n_checks++;
        if (ready_o !== 1'b1) $display("FAIL bp_release_ready: got %b, required 1", ready_o); else n_pass++;
        @(posedge clk);
        #1 valid_i = 1'b0;
        @(negedge clk);
        n_checks++;
        if (valid_o !== 1'b1 || data_o !== exp_b)
            $display("FAIL bp_second: valid_o=%b data_o=%h, required 1/%h", valid_o, data_o, exp_b);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [2:0]       op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] exp;
        localparam int N = 20;
        @(negedge clk);
        ready_i = 1'b1;
        for (int i = 0; i <= N; i++) begin
            @(negedge clk);
            if (i > 0) begin
                exp = exp_q.pop_front();
                n_checks++;
                if (valid_o !== 1'b1 || data_o !== exp)
                    $display("FAIL b2b_result[%0d]: valid_o=%b data_o=%h, required 1/%h", i - 1, valid_o, data_o, exp);
                else n_pass++;
            end
            if (i < N) begin
                op = 3'($urandom_range(0, 6));
                if (op == OPC_MUL) op = OPC_SRAI;
                a = pick_operand();
                b = pick_operand();
                ctrl_i  = op;
                data1_i = a;
                data2_i = b;
                valid_i = 1'b1;
                exp_q.push_back(model(op, a, b));
                n_checks++;
                if (ready_o !== 1'b1) $display("FAIL b2b_ready[%0d]: got %b, required 1", i, ready_o);
                else n_pass++;
            end else begin
                valid_i = 1'b0;
            end
        end
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL b2b_queue: %0d results left, required 0", exp_q.size());
        else n_pass++;
    endtask

    task automatic test_mul_reset();
        int   lat;
        logic busy_ok;
        int   seen;
        @(negedge clk);
        ctrl_i  = OPC_MUL;
        data1_i = $urandom;
        data2_i = $urandom;
        valid_i = 1'b1;
        @(posedge clk);
        #1 valid_i = 1'b0;
        repeat (10) @(negedge clk);
`ifdef ITER_MUL_EN
        n_checks++;
        if (ready_o !== 1'b0 || valid_o !== 1'b0 || dbg_state_o !== 2'd1)
            $display("FAIL mulrst_busy: ready_o=%b valid_o=%b state=%0d, required 0/0/1", ready_o, valid_o, dbg_state_o);
        else n_pass++;
`endif
        rst_i = 1'b1;
        @(posedge clk);
        #1 rst_i = 1'b0;
        @(negedge clk);
        n_checks++;
        if (valid_o !== 1'b0 || ready_o !== 1'b1 || dbg_state_o !== 2'd0)
            $display("FAIL mulrst_after: valid_o=%b ready_o=%b state=%0d, required 0/1/0", valid_o, ready_o, dbg_state_o);
        else n_pass++;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (valid_o) seen++;
        end
        n_checks++;
        if (seen != 0) $display("FAIL mulrst_no_result: valid_o high %0d cycles, required 0", seen);
        else n_pass++;
        run_op(OPC_AND, 32'h0000_F0F0, 32'h0000_0FF0, lat, busy_ok);
        n_checks++;
        if (data_o !== 32'h0000_00F0 || lat !== 1)
            $display("FAIL mulrst_and: data_o=%h lat=%0d, required 000000f0/1", data_o, lat);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_mul_reset();
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
